conv_backward_input: RTL and testbench

Sequential input-gradient engine for the backward pass of the same-padded, stride-1 fixed-point convolution layer. It computes grad_in[ci][r][c] = sum over co, m, n of grad_out[co][r-m+P][c-n+P] * kernels[m][n][ci][co], with P = KERNEL_SIZE/2 and out-of-range taps contributing zero. The result is shifted right by FRAC. The block uses one multiply-accumulate per clock, so a training pipeline can reuse the forward layer's kernel array and tensor layouts without a large combinational array.

---
 rtl/conv_backward_input.sv | 190 +++++++++++++++++++
 tb/tb_conv_backward_input.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_backward_input.sv
`timescale 1ns/1ps
// Input-gradient engine for a same-padded, stride-1 conv layer: one MAC per clock, results written
// element by element. Define CONV_BWD_SAT_EN to clamp results instead of two's-complement wrap.
module conv_backward_input #(
  parameter int IN_DEPTH    = 3,
  parameter int IN_HEIGHT   = 4,
  parameter int IN_WIDTH    = 4,
  parameter int OUT_DEPTH   = 2,
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_W      = 16,
  parameter int FRAC        = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] grad_out [0:OUT_DEPTH-1][0:IN_HEIGHT-1][0:IN_WIDTH-1],
  input  logic signed [DATA_W-1:0] kernels  [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][0:IN_DEPTH-1][0:OUT_DEPTH-1],
  output logic                     busy,
  output logic                     done,
  output logic                     grad_in_valid,
  output logic signed [DATA_W-1:0] grad_in  [0:IN_DEPTH-1][0:IN_HEIGHT-1][0:IN_WIDTH-1]
);

  localparam int P     = KERNEL_SIZE / 2;
  localparam int TAPS  = OUT_DEPTH * KERNEL_SIZE * KERNEL_SIZE;
  localparam int ACC_W = 2 * DATA_W + $clog2(TAPS);
  localparam int CI_W  = (IN_DEPTH    > 1) ? $clog2(IN_DEPTH)    : 1;
  localparam int H_W   = (IN_HEIGHT   > 1) ? $clog2(IN_HEIGHT)   : 1;
  localparam int W_W   = (IN_WIDTH    > 1) ? $clog2(IN_WIDTH)    : 1;
  localparam int CO_W  = (OUT_DEPTH   > 1) ? $clog2(OUT_DEPTH)   : 1;
  localparam int K_W   = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

  localparam logic [CI_W-1:0] CI_LAST = CI_W'(IN_DEPTH - 1);
  localparam logic [H_W-1:0]  R_LAST  = H_W'(IN_HEIGHT - 1);
  localparam logic [W_W-1:0]  C_LAST  = W_W'(IN_WIDTH - 1);
  localparam logic [CO_W-1:0] CO_LAST = CO_W'(OUT_DEPTH - 1);
  localparam logic [K_W-1:0]  K_LAST  = K_W'(KERNEL_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_DONE} state_t;

  state_t                   r_state;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CI_W-1:0]          r_ci;
  logic [H_W-1:0]           r_r;
  logic [W_W-1:0]           r_c;
  logic [CO_W-1:0]          r_co;
  logic [K_W-1:0]           r_m;
  logic [K_W-1:0]           r_n;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_valid;
  logic signed [DATA_W-1:0] r_grad_in [0:IN_DEPTH-1][0:IN_HEIGHT-1][0:IN_WIDTH-1];
  logic signed [DATA_W-1:0] r_gout    [0:OUT_DEPTH-1][0:IN_HEIGHT-1][0:IN_WIDTH-1];
  logic signed [DATA_W-1:0] r_kern    [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][0:IN_DEPTH-1][0:OUT_DEPTH-1];

  int                        w_sr;
  int                        w_sc;
  logic                      w_tap_ok;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]   w_shift;
  logic                      w_last_tap;
  logic                      w_last_elem;

  // Reduce the shifted accumulator to the output word width.
  function automatic logic signed [DATA_W-1:0] reduce_fn(input logic signed [ACC_W-1:0] v);
`ifdef CONV_BWD_SAT_EN
    logic signed [ACC_W-1:0] sat_max;
    logic signed [ACC_W-1:0] sat_min;
    sat_max = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    sat_min = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    if (v > sat_max)
      return sat_max[DATA_W-1:0];
    else if (v < sat_min)
      return sat_min[DATA_W-1:0];
    else
      return v[DATA_W-1:0];
`else
    return DATA_W'(v);
`endif
  endfunction

  // Padding taps fall outside the map and contribute nothing, but still consume their cycle.
  always_comb begin
    w_sr     = int'(r_r) - int'(r_m) + P;
    w_sc     = int'(r_c) - int'(r_n) + P;
    w_tap_ok = (w_sr >= 0) && (w_sr < IN_HEIGHT) && (w_sc >= 0) && (w_sc < IN_WIDTH);
    w_prod   = '0;
    if (w_tap_ok)
      w_prod = r_gout[r_co][w_sr[H_W-1:0]][w_sc[W_W-1:0]] * r_kern[r_m][r_n][r_ci][r_co];
  end

  assign w_shift     = r_acc >>> FRAC;
  assign w_last_tap  = (r_co == CO_LAST) && (r_m == K_LAST) && (r_n == K_LAST);
  assign w_last_elem = (r_ci == CI_LAST) && (r_r == R_LAST) && (r_c == C_LAST);

  // Operand snapshot taken on the accepting edge so mid-run input changes are ignored.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start) begin
      r_gout <= grad_out;
      r_kern <= kernels;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_ci    <= '0;
      r_r     <= '0;
      r_c     <= '0;
      r_co    <= '0;
      r_m     <= '0;
      r_n     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      for (int i = 0; i < IN_DEPTH; i++)
        for (int j = 0; j < IN_HEIGHT; j++)
          for (int k = 0; k < IN_WIDTH; k++)
            r_grad_in[i][j][k] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc   <= '0;
            r_ci    <= '0;
            r_r     <= '0;
            r_c     <= '0;
            r_co    <= '0;
            r_m     <= '0;
            r_n     <= '0;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
            r_state <= S_MAC;
          end
        end
        // Tap order: n fastest, then m, then co.
        S_MAC: begin
          r_acc <= r_acc + ACC_W'(w_prod);
          if (r_n == K_LAST) begin
            r_n <= '0;
            if (r_m == K_LAST) begin
              r_m <= '0;
              r_co <= (r_co == CO_LAST) ? '0 : r_co + CO_W'(1);
            end else begin
              r_m <= r_m + K_W'(1);
            end
          end else begin
            r_n <= r_n + K_W'(1);
          end
          if (w_last_tap)
            r_state <= S_WRITE;
        end
        // Element order: c fastest, then r, then ci.
        S_WRITE: begin
          r_grad_in[r_ci][r_r][r_c] <= reduce_fn(w_shift);
          r_acc <= '0;
          if (r_c == C_LAST) begin
            r_c <= '0;
            if (r_r == R_LAST) begin
              r_r  <= '0;
              r_ci <= (r_ci == CI_LAST) ? '0 : r_ci + CI_W'(1);
            end else begin
              r_r <= r_r + H_W'(1);
            end
          end else begin
            r_c <= r_c + W_W'(1);
          end
          if (w_last_elem) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_MAC;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign grad_in_valid = r_valid;
  assign grad_in       = r_grad_in;

endmodule

// File: tb/tb_conv_backward_input.sv
`timescale 1ns/1ps
// Directed bench for conv_backward_input: hand-computed gradients, latency, reset and restart behaviour.
module tb_conv_backward_input;

  localparam int ID = 3, IH = 4, IW = 4, OD = 2, KS = 3, DW = 16;
  localparam int LAT = 912;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic signed [DW-1:0] grad_out [0:OD-1][0:IH-1][0:IW-1];
  logic signed [DW-1:0] kernels  [0:KS-1][0:KS-1][0:ID-1][0:OD-1];
  logic busy, done, grad_in_valid;
  logic signed [DW-1:0] grad_in  [0:ID-1][0:IH-1][0:IW-1];

  int n_vec = 0;
  int n_err = 0;
  int cyc;
  logic signed [DW-1:0] ovf_exp;

  conv_backward_input dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .grad_out      (grad_out),
    .kernels       (kernels),
    .busy          (busy),
    .done          (done),
    .grad_in_valid (grad_in_valid),
    .grad_in       (grad_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic signed [DW-1:0] g, input logic signed [DW-1:0] k);
    for (int a = 0; a < OD; a++)
      for (int b = 0; b < IH; b++)
        for (int c = 0; c < IW; c++)
          grad_out[a][b][c] = g;
    for (int a = 0; a < KS; a++)
      for (int b = 0; b < KS; b++)
        for (int c = 0; c < ID; c++)
          for (int d = 0; d < OD; d++)
            kernels[a][b][c][d] = k;
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the accepting edge.
  task automatic kick();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("valid_low_after_accept", grad_in_valid, 0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (done !== 1'b1 && n < 2000);
  endtask

  task automatic after_done(input string tag);
    chk({tag, "_latency_valid"}, grad_in_valid, 1);
    chk({tag, "_busy_low"}, busy, 0);
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, done, 0);
  endtask

  task automatic check_ones(input string tag);
    for (int ci = 0; ci < ID; ci++) begin
      chk($sformatf("%s_gi[%0d][1][1]", tag, ci), grad_in[ci][1][1], 288);
      chk($sformatf("%s_gi[%0d][0][1]", tag, ci), grad_in[ci][0][1], 192);
      chk($sformatf("%s_gi[%0d][0][0]", tag, ci), grad_in[ci][0][0], 128);
      chk($sformatf("%s_gi[%0d][3][3]", tag, ci), grad_in[ci][3][3], 128);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fill(0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", grad_in_valid, 0);
    chk("rst_gi000", grad_in[0][0][0], 0);
    chk("rst_gi233", grad_in[2][3][3], 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);

    // All-ones run, with start toggled and inputs corrupted mid-run.
    fill(16, 16);
    kick();
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 50) begin
        fill(0, 16'sh7FFF);
        start = 1'b1;
      end
      if (cyc == 52) start = 1'b0;
      if (cyc == 300) chk("valid_low_midrun", grad_in_valid, 0);
    end while (done !== 1'b1 && cyc < 2000);
    chk("ones_latency", cyc, LAT);
    check_ones("ones");
    after_done("ones");

    // Single impulse through a ramp kernel.
    fill(0, 0);
    grad_out[0][0][0] = 16;
    for (int m = 0; m < KS; m++)
      for (int n = 0; n < KS; n++)
        kernels[m][n][0][0] = 16'(16 * (3 * m + n + 1));
    kick();
    wait_done(cyc);
    chk("imp_latency", cyc, LAT);
    chk("imp_gi000", grad_in[0][0][0], 80);
    chk("imp_gi001", grad_in[0][0][1], 96);
    chk("imp_gi011", grad_in[0][1][1], 144);
    chk("imp_gi010", grad_in[0][1][0], 128);
    for (int ci = 1; ci < ID; ci++)
      for (int r = 0; r < IH; r++)
        for (int c = 0; c < IW; c++)
          chk($sformatf("imp_zero_gi[%0d][%0d][%0d]", ci, r, c), grad_in[ci][r][c], 0);
    after_done("imp");

    // Asynchronous reset partway through a run.
    fill(16, 16);
    kick();
    repeat (99) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_valid", grad_in_valid, 0);
    for (int ci = 0; ci < ID; ci++)
      for (int r = 0; r < IH; r++)
        for (int c = 0; c < IW; c++)
          chk($sformatf("midrst_gi[%0d][%0d][%0d]", ci, r, c), grad_in[ci][r][c], 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    kick();
    wait_done(cyc);
    chk("rerun_latency", cyc, LAT);
    check_ones("rerun");
    after_done("rerun");

    // Full-scale operands overflow the output word.
`ifdef CONV_BWD_SAT_EN
    ovf_exp = 16'sh7FFF;
`else
    ovf_exp = 16'shE001;
`endif
    fill(16'sh7FFF, 16'sh7FFF);
    kick();
    wait_done(cyc);
    chk("ovf_latency", cyc, LAT);
    for (int ci = 0; ci < ID; ci++)
      chk($sformatf("ovf_gi[%0d][1][1]", ci), grad_in[ci][1][1], ovf_exp);
    after_done("ovf");

    // Start held high: second run accepted on the edge after DONE.
    fill(16, 16);
    start = 1'b1;
    @(posedge clk); #1;
    chk("b2b_busy1", busy, 1);
    wait_done(cyc);
    chk("b2b_latency1", cyc, LAT);
    chk("b2b_valid1", grad_in_valid, 1);
    @(posedge clk); #1;
    chk("b2b_done_low", done, 0);
    chk("b2b_valid_in_idle", grad_in_valid, 1);
    chk("b2b_busy_in_idle", busy, 0);
    @(posedge clk); #1;
    chk("b2b_reaccept_busy", busy, 1);
    chk("b2b_reaccept_valid", grad_in_valid, 0);
    start = 1'b0;
    wait_done(cyc);
    chk("b2b_latency2", cyc, LAT);
    chk("b2b_gi011", grad_in[0][1][1], 288);
    after_done("b2b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
